// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and helpers for the traffic phase controller.
//   state_e   - controller state encoding (2'b11 is illegal, recovers to all-red)
//   ph_width  - index width needed to address n phases (at least 1 bit)
package traffic_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_GREEN  = 2'b00,
        ST_YELLOW = 2'b01,
        ST_ALLRED = 2'b10
    } state_e;

    function automatic int unsigned ph_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/traffic_next_phase.sv
// traffic_next_phase: combinational round-robin selector for the next served phase.
//   cur_phase    in  PH_W        phase currently being served
//   dem_lat      in  NUM_PHASES  latched demands (bit 0 treated as always set)
//   next_phase_c out PH_W        first qualifying phase after cur_phase, wrapping
module traffic_next_phase
    import traffic_pkg::*;
#(
    parameter int unsigned NUM_PHASES = 4,
    parameter int unsigned PH_W       = ph_width(NUM_PHASES)
) (
    input  logic [PH_W-1:0]       cur_phase,
    input  logic [NUM_PHASES-1:0] dem_lat,
    output logic [PH_W-1:0]       next_phase_c
);

    logic [NUM_PHASES-1:0] qual_c;
    int                    dist_c;
    int                    best_c;

    // Pick the qualifying phase with the smallest forward distance; the
    // current phase itself sits at distance NUM_PHASES (re-serve last).
    always_comb begin
        qual_c       = dem_lat | NUM_PHASES'(1);
        best_c       = int'(NUM_PHASES) + 1;
        dist_c       = 0;
        next_phase_c = '0;
        for (int i = 0; i < int'(NUM_PHASES); i++) begin
            dist_c = (i + int'(NUM_PHASES) - int'(cur_phase)) % int'(NUM_PHASES);
            if (dist_c == 0) begin
                dist_c = int'(NUM_PHASES);
            end
            if (qual_c[i] && (dist_c < best_c)) begin
                best_c       = dist_c;
                next_phase_c = PH_W'(i);
            end
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: multi-phase signal controller, GREEN -> YELLOW -> ALLRED per phase,
// skipping undemanded phases (phase 0 is recall), with hold freezing the green timer.
//   clk, reset          clock, asynchronous active-high reset
//   tick                timebase strobe; all durations count ticks
//   green_ticks         per-phase green duration, phase i at [i*CNT_W +: CNT_W]
//   demand              per-phase service request (bit 0 ignored)
//   hold                freezes the green timer while high
//   green/yellow/red    lamp drives, registered
//   phase, state        currently served phase and state encoding
//   phase_done          one-cycle pulse after each ALLRED -> GREEN edge
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned NUM_PHASES   = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned YELLOW_TICKS = 5,
    parameter int unsigned ALLRED_TICKS = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic [NUM_PHASES*CNT_W-1:0] green_ticks,
    input  logic [NUM_PHASES-1:0]       demand,
    input  logic                        hold,
    output logic [NUM_PHASES-1:0]       green,
    output logic [NUM_PHASES-1:0]       yellow,
    output logic [NUM_PHASES-1:0]       red,
    output logic [ph_width(NUM_PHASES)-1:0] phase,
    output logic [STATE_W-1:0]          state,
    output logic                        phase_done
);

    localparam int unsigned PH_W = ph_width(NUM_PHASES);

    state_e                  state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [CNT_W-1:0]        green_dur_q, green_dur_d;
    logic [NUM_PHASES-1:0]   dem_lat_q, dem_lat_d;
    logic [NUM_PHASES-1:0]   green_q, green_d;
    logic [NUM_PHASES-1:0]   yellow_q, yellow_d;
    logic [NUM_PHASES-1:0]   red_q, red_d;
    logic                    phase_done_q, phase_done_d;

    logic [PH_W-1:0]         next_phase_c;
    logic [CNT_W-1:0]        sel_green_c;
    logic [CNT_W-1:0]        dur_c;
    logic                    in_green_c;
    logic                    adv_c;
    logic                    expire_c;

    traffic_next_phase #(
        .NUM_PHASES (NUM_PHASES),
        .PH_W       (PH_W)
    ) u_next_phase (
        .cur_phase    (phase_q),
        .dem_lat      (dem_lat_q),
        .next_phase_c (next_phase_c)
    );

    // Green duration of the phase that would be entered next.
    always_comb begin
        sel_green_c = '0;
        for (int i = 0; i < int'(NUM_PHASES); i++) begin
            if (next_phase_c == PH_W'(i)) begin
                sel_green_c = green_ticks[i*CNT_W +: CNT_W];
            end
        end
    end

    // Next-state, timer, demand latch and output decode.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        count_d      = count_q;
        green_dur_d  = green_dur_q;
        phase_done_d = 1'b0;
        dem_lat_d    = dem_lat_q;
        green_d      = '0;
        yellow_d     = '0;
        red_d        = '1;

        in_green_c = (state_q == ST_GREEN);

        // A phase's own demand is not latched while it is green.
        for (int i = 0; i < int'(NUM_PHASES); i++) begin
            if (demand[i] && !(in_green_c && (phase_q == PH_W'(i)))) begin
                dem_lat_d[i] = 1'b1;
            end
        end

        case (state_q)
            ST_GREEN:  dur_c = green_dur_q;
            ST_YELLOW: dur_c = CNT_W'(YELLOW_TICKS);
            default:   dur_c = CNT_W'(ALLRED_TICKS);
        endcase

        adv_c    = tick && !(in_green_c && hold);
        expire_c = adv_c && (count_q == (dur_c - CNT_W'(1)));

        if (adv_c) begin
            count_d = expire_c ? '0 : (count_q + CNT_W'(1));
        end

        if (expire_c) begin
            case (state_q)
                ST_GREEN:  state_d = ST_YELLOW;
                ST_YELLOW: state_d = ST_ALLRED;
                ST_ALLRED: begin
                    state_d      = ST_GREEN;
                    phase_d      = next_phase_c;
                    green_dur_d  = (sel_green_c == '0) ? CNT_W'(1) : sel_green_c;
                    phase_done_d = 1'b1;
                    // Clear on entry wins over a same-cycle set.
                    for (int i = 0; i < int'(NUM_PHASES); i++) begin
                        if (next_phase_c == PH_W'(i)) begin
                            dem_lat_d[i] = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Illegal encoding falls back to clearance.
        if (!(state_q inside {ST_GREEN, ST_YELLOW, ST_ALLRED})) begin
            state_d = ST_ALLRED;
            count_d = '0;
        end

        for (int i = 0; i < int'(NUM_PHASES); i++) begin
            green_d[i]  = (state_d == ST_GREEN)  && (phase_d == PH_W'(i));
            yellow_d[i] = (state_d == ST_YELLOW) && (phase_d == PH_W'(i));
        end
        red_d = ~(green_d | yellow_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_ALLRED;
            phase_q      <= PH_W'(NUM_PHASES - 1);
            count_q      <= '0;
            green_dur_q  <= CNT_W'(1);
            dem_lat_q    <= '0;
            green_q      <= '0;
            yellow_q     <= '0;
            red_q        <= '1;
            phase_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            count_q      <= count_d;
            green_dur_q  <= green_dur_d;
            dem_lat_q    <= dem_lat_d;
            green_q      <= green_d;
            yellow_q     <= yellow_d;
            red_q        <= red_d;
            phase_done_q <= phase_done_d;
        end
    end

    assign green      = green_q;
    assign yellow     = yellow_q;
    assign red        = red_q;
    assign phase      = phase_q;
    assign state      = state_q;
    assign phase_done = phase_done_q;

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised multi-phase traffic signal controller. It sequences NUM_PHASES approaches through GREEN, YELLOW and ALL-RED clearance. Each phase has its own run-time green duration. Phases are skipped when they have no demand, and green can be frozen by a hold input. It sits under the intersection top level: it takes a slow timebase strobe from the shared tick generator and drives the lamp-driver outputs directly.

## Interface
- NUM_PHASES, 4: number of approaches; legal range 2..8.
- CNT_W, 8: width of per-phase green durations and of the internal tick counter.
- YELLOW_TICKS, 5: yellow duration in ticks; must be at least 1.
- ALLRED_TICKS, 2: all-red clearance duration in ticks; must be at least 1.

Ports (PH_W = $clog2(NUM_PHASES)):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- tick  in  1  one-cycle timebase strobe; all durations are counted in ticks.
- green_ticks  in  NUM_PHASES*CNT_W  per-phase green duration; phase i uses bits [i*CNT_W +: CNT_W].
- demand  in  NUM_PHASES  per-phase service request (level or pulse); bit 0 is ignored.
- hold  in  1  freezes the green timer while high.
- green  out  NUM_PHASES  one-hot or zero.
- yellow  out  NUM_PHASES  one-hot or zero.
- red  out  NUM_PHASES  red[i] = ~(green[i] | yellow[i]).
- phase  out  PH_W  currently served phase.
- state  out  2  current FSM state encoding.
- phase_done  out  1  one-cycle pulse on exit from ALLRED.

## Operation
- States: GREEN, YELLOW, ALLRED. Transitions: GREEN to YELLOW to ALLRED to GREEN of the next phase.
- Reset values:
  - state = ALLRED, phase = NUM_PHASES-1, count = 0, demand latches = 0.
  - green = 0, yellow = 0, red = all ones, phase_done = 0.
- Timer:
  - count increments only on tick.
  - When tick is high and count == dur-1, the state advances and count returns to 0.
  - dur is green_dur in GREEN, YELLOW_TICKS in YELLOW, ALLRED_TICKS in ALLRED.
- Green duration: green_ticks for the selected phase is captured into green_dur on entry to GREEN. A captured value of 0 is treated as 1. Changing green_ticks mid-green has no effect on the current green.
- Hold: in GREEN with hold high, ticks are ignored and count is frozen. Hold has no effect in YELLOW or ALLRED.
- Demand latching:
  - dem_lat[i] is set on any cycle where demand[i] is high, except while phase i is in GREEN.
  - dem_lat[i] is cleared on the edge entering GREEN for phase i. Clear wins over a simultaneous set.
  - Phase 0 is the recall phase and is always considered demanded.
- Next-phase selection, evaluated at ALLRED expiry:
  - Round-robin search from phase+1, wrapping, for the first index with dem_lat set or index 0.
  - If phase 0 is current and no other demand exists, phase 0 is re-served.
- phase_done is high for exactly the one clk following the ALLRED-to-GREEN edge.
- Arithmetic: count is CNT_W bits. Counter bits that cannot be reached for YELLOW/ALLRED are unused. No wrap occurs because of the dur-1 compare.

## Timing
- All outputs are registered, or decoded purely from registered state and phase; no input-to-output combinational path.
- A qualifying tick at edge k makes the new state visible from edge k onward, so output latency is one clk after the tick cycle.
- With tick tied high, the green for phase i lasts exactly max(green_ticks_i, 1) clk cycles. Yellow lasts YELLOW_TICKS cycles and all-red lasts ALLRED_TICKS cycles.
- Reset asserted mid-operation forces the reset values immediately (asynchronous), including clearing all demand latches.
- After reset release, the first green is phase 0, after ALLRED_TICKS ticks.
- A demand pulse of a single cycle is sufficient; it is held in the latch until that phase is served.

## Structure
- Shared package traffic_pkg:
  - state typedef with encodings ST_GREEN = 2'b00, ST_YELLOW = 2'b01, ST_ALLRED = 2'b10; 2'b11 is illegal and recovers to ST_ALLRED.
  - Phase-width helper constant.
- Sub-module traffic_next_phase: a combinational round-robin selector.
  - Inputs: current phase, dem_lat.
  - Output: next phase index.
  - This keeps the search logic independently testable.

## Test plan
- Reset, tick high, all green_ticks = 3, no demand: phase 0 repeats GREEN 3, YELLOW 5, ALLRED 2 cycles. phase_done pulses every 10 cycles after the first ALLRED.
- Single-cycle demand[2] pulse during phase-0 green (NUM_PHASES = 4): phases 1 and 3 are skipped. Order is 0 then 2 then 0, and dem_lat[2] clears on entry to green for phase 2.
- Demands on phases 1, 2 and 3 all set: service order is 0, 1, 2, 3, 0 (wraps correctly). Demand[1] asserted during phase-1 green is not re-latched.
- hold high for 7 cycles during a 4-tick green: green lasts 11 cycles. The same hold applied in YELLOW does not stretch yellow.
- green_ticks for phase 0 = 0: green lasts 1 tick. Changing green_ticks mid-green does not alter the current green.
- Reset asserted mid-YELLOW of phase 2 with pending demands: outputs go all red immediately and latches clear. After release, phase 0 green starts after 2 ticks.
